// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 signed multiply/divide unit that writes its results to HI/LO.
// Optional build macro MDU_EARLY_TERM_EN lets mult leave RUN once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  ALU_Control,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivByZero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam logic [3:0]  OP_MULT = 4'b0101;
  localparam logic [3:0]  OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     amag_q, amag_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             busy_q, done_q, dbz_q;

  logic             op_ok_c, accept_c, last_iter_c, mult_exit_c;
  logic [W-1:0]     a_mag_c, b_mag_c;
  logic [W:0]       rem_sh_c, trial_c;
  logic [2*W-1:0]   prod_res_c;
  logic [W-1:0]     quo_c, rem_src_c, rem_c;

  assign op_ok_c  = (ALU_Control == OP_MULT) || (ALU_Control == OP_DIV);
  assign accept_c = Start && op_ok_c && ((state_q == IDLE) || (state_q == DONE));
  assign a_mag_c  = A[W-1] ? (~A + 32'd1) : A;
  assign b_mag_c  = B[W-1] ? (~B + 32'd1) : B;

  // Division step: acc holds {remainder, dividend/quotient}; shift one bit and trial-subtract.
  assign rem_sh_c = acc_q[2*W-1:W-1];
  assign trial_c  = rem_sh_c - {1'b0, mcand_q[W-1:0]};

  // Sign correction applied while in FIX.
  assign prod_res_c = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_c      = neg_q ? (~acc_q[W-1:0] + 32'd1) : acc_q[W-1:0];
  assign rem_src_c  = div0_q ? amag_q : acc_q[2*W-1:W];
  assign rem_c      = rneg_q ? (~rem_src_c + 32'd1) : rem_src_c;

`ifdef MDU_EARLY_TERM_EN
  assign mult_exit_c = !is_div_q && (mplier_q[W-1:1] == '0);
`else
  assign mult_exit_c = 1'b0;
`endif

  assign last_iter_c = (cnt_q == 5'd31) || mult_exit_c;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    cnt_d    = cnt_q;
    amag_d   = amag_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          if (!trial_c[W]) acc_d = {trial_c[W-1:0], acc_q[W-2:0], 1'b1};
          else             acc_d = {rem_sh_c[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = {mcand_q[2*W-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[W-1:1]};
        end
        if (last_iter_c) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = div0_q ? DIV0_QUOTIENT : quo_c;
          hi_d = rem_c;
        end else begin
          lo_d = prod_res_c[W-1:0];
          hi_d = prod_res_c[2*W-1:W];
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operand capture; only reachable from IDLE or DONE.
    if (accept_c) begin
      state_d  = RUN;
      is_div_d = (ALU_Control == OP_DIV);
      neg_d    = A[W-1] ^ B[W-1];
      rneg_d   = A[W-1];
      div0_d   = (ALU_Control == OP_DIV) && (B == '0);
      cnt_d    = '0;
      amag_d   = a_mag_c;
      mcand_d  = {{W{1'b0}}, (ALU_Control == OP_DIV) ? b_mag_c : a_mag_c};
      mplier_d = b_mag_c;
      acc_d    = (ALU_Control == OP_DIV) ? {{W{1'b0}}, a_mag_c} : '0;
    end

    // Flush wins over everything and never touches the result registers.
    if (Flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      amag_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
      amag_q   <= amag_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d == RUN) || (state_d == FIX);
      done_q   <= (state_d == DONE);
      dbz_q    <= (state_d == DONE) && div0_q;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign DivByZero = dbz_q;

endmodule
